btle_rx_core_unit: RTL and testbench

Bluetooth LE 1 Msym/s receiver core. It takes one complex baseband sample per bit, performs differential GFSK demodulation, and searches for the 32-bit access address. After a match it de-whitens the PDU, extracts the payload length, and streams the decoded bits and octets. It then checks CRC24 and reports the result. The block sits between the RF front-end sample stream (1 sample per symbol, arbitrary clock-enable spacing) and the link-layer packet buffer.

---
 rtl/btle_rx_core_unit.sv | 192 +++++++++++++++++++
 tb/tb_btle_rx_core_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/btle_rx_core_unit.sv
// rtl/btle_rx_core_unit.sv - BLE 1 Msym/s receiver: GFSK demod, access-address search, de-whitening, CRC24
// De-whitening LFSR is built only when BTLE_RX_DEWHITEN_EN is defined; otherwise bits pass through raw.
module btle_rx_core_unit #(
   parameter int GFSK_DEMODULATION_BIT_WIDTH = 16,
   parameter int LEN_UNIQUE_BIT_SEQUENCE     = 32,
   parameter int CHANNEL_NUMBER_BIT_WIDTH    = 6,
   parameter int CRC_STATE_BIT_WIDTH         = 24
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic        [LEN_UNIQUE_BIT_SEQUENCE-1:0]     unique_bit_sequence,
   input  logic        [CHANNEL_NUMBER_BIT_WIDTH-1:0]    channel_number,
   input  logic        [CRC_STATE_BIT_WIDTH-1:0]         crc_state_init_bit,
   input  logic signed [GFSK_DEMODULATION_BIT_WIDTH-1:0] i,
   input  logic signed [GFSK_DEMODULATION_BIT_WIDTH-1:0] q,
   input  logic                                          iq_valid,
   output logic                                          hit_flag,
   output logic        [6:0]                             payload_length,
   output logic                                          payload_length_valid,
   output logic                                          info_bit,
   output logic                                          bit_valid,
   output logic        [7:0]                             octet,
   output logic                                          octet_valid,
   output logic                                          decode_end,
   output logic                                          crc_ok
);
   localparam int W   = GFSK_DEMODULATION_BIT_WIDTH;
   localparam int AW  = LEN_UNIQUE_BIT_SEQUENCE;
   localparam int CW  = CRC_STATE_BIT_WIDTH;
   localparam int DW  = 2 * W + 1;
   localparam int RW  = 11;
   localparam int CIW = $clog2(CW);
   localparam logic [CW-1:0] CRC_POLY = CW'(24'h00065B);

   typedef enum logic [1:0] {S_SEARCH, S_HEADER, S_PAYLOAD} state_t;

   state_t              state_q;
   logic signed [W-1:0] i_prev_q, q_prev_q;
   logic                demod_q, demod_vld_q;
   logic [AW-1:0]       sr_q, sr_d;
   logic [3:0]          cnt_q;
   logic [RW-1:0]       rem_q;
   logic [CW-1:0]       crc_q, crc_d;
   logic                crc_err_q;
   logic [7:0]          oct_sr_q, oct_d;
   logic                oct_full_q, hdr_done_q, end_pend_q;
   logic                hit_q, info_q, bit_vld_q, oct_vld_q, len_vld_q, dec_end_q, crc_ok_q;
   logic [7:0]          octet_q;
   logic [6:0]          len_q;
   logic signed [DW-1:0] d;
   logic                white, info_d, fb, hit_d, bit_adv;
   logic [CIW-1:0]      crc_idx;

   assign d = DW'(i_prev_q) * DW'(q) - DW'(q_prev_q) * DW'(i);

   always_comb begin
      sr_d    = {demod_q, sr_q[AW-1:1]};
      info_d  = demod_q ^ white;
      fb      = crc_q[CW-1] ^ info_d;
      crc_d   = {crc_q[CW-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
      oct_d   = {info_d, oct_sr_q[7:1]};
      crc_idx = CIW'(rem_q - RW'(1));
      hit_d   = demod_vld_q && (state_q == S_SEARCH) && (sr_d == unique_bit_sequence);
      bit_adv = demod_vld_q && (state_q != S_SEARCH);
   end

`ifdef BTLE_RX_DEWHITEN_EN
   logic [6:0] wh_q, wh_d, wh_init;

   always_comb begin
      wh_init[0] = 1'b1;
      for (int k = 1; k < 7; k++) wh_init[k] = channel_number[6-k];
      wh_d = {wh_q[5:4], wh_q[3] ^ wh_q[6], wh_q[2:0], wh_q[6]};
   end

   assign white = wh_q[6];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       wh_q <= '0;
      else if (hit_d)   wh_q <= wh_init;
      else if (bit_adv) wh_q <= wh_d;
   end
`else
   logic unused_channel;
   assign white          = 1'b0;
   assign unused_channel = ^channel_number;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_SEARCH;
         i_prev_q    <= '0;
         q_prev_q    <= '0;
         demod_q     <= 1'b0;
         demod_vld_q <= 1'b0;
         sr_q        <= '0;
         cnt_q       <= '0;
         rem_q       <= '0;
         crc_q       <= '0;
         crc_err_q   <= 1'b0;
         oct_sr_q    <= '0;
         oct_full_q  <= 1'b0;
         hdr_done_q  <= 1'b0;
         end_pend_q  <= 1'b0;
         hit_q       <= 1'b0;
         info_q      <= 1'b0;
         bit_vld_q   <= 1'b0;
         octet_q     <= '0;
         oct_vld_q   <= 1'b0;
         len_q       <= '0;
         len_vld_q   <= 1'b0;
         dec_end_q   <= 1'b0;
         crc_ok_q    <= 1'b0;
      end else begin
         hit_q       <= 1'b0;
         bit_vld_q   <= 1'b0;
         oct_full_q  <= 1'b0;
         hdr_done_q  <= 1'b0;
         end_pend_q  <= 1'b0;
         oct_vld_q   <= 1'b0;
         len_vld_q   <= 1'b0;
         dec_end_q   <= 1'b0;
         demod_vld_q <= iq_valid;

         if (iq_valid) begin
            demod_q  <= ~d[DW-1] & (|d);
            i_prev_q <= i;
            q_prev_q <= q;
         end

         // Octet/length/end reports trail the bit that completes them by one cycle
         if (oct_full_q) begin
            octet_q   <= oct_sr_q;
            oct_vld_q <= 1'b1;
         end
         if (hdr_done_q) begin
            len_q     <= oct_sr_q[6:0];
            len_vld_q <= 1'b1;
         end
         if (end_pend_q) begin
            dec_end_q <= 1'b1;
            crc_ok_q  <= ~crc_err_q;
         end

         if (hit_d) begin
            sr_q      <= sr_d;
            hit_q     <= 1'b1;
            state_q   <= S_HEADER;
            cnt_q     <= '0;
            crc_q     <= crc_state_init_bit;
            crc_err_q <= 1'b0;
            crc_ok_q  <= 1'b0;
         end else if (demod_vld_q && state_q == S_SEARCH) begin
            sr_q <= sr_d;
         end else if (bit_adv) begin
            info_q    <= info_d;
            bit_vld_q <= 1'b1;
            oct_sr_q  <= oct_d;
            cnt_q     <= cnt_q + 4'd1;
            if (cnt_q[2:0] == 3'd7) oct_full_q <= 1'b1;
            if (state_q == S_HEADER) begin
               crc_q <= crc_d;
               if (cnt_q == 4'd15) begin
                  hdr_done_q <= 1'b1;
                  rem_q      <= RW'({oct_sr_q[7:1], 3'b000}) + RW'(CW);
                  state_q    <= S_PAYLOAD;
               end
            end else begin
               // Last CW bits are the received CRC, checked against the frozen register
               if (rem_q > RW'(CW)) crc_q <= crc_d;
               else if (info_d != crc_q[crc_idx]) crc_err_q <= 1'b1;
               rem_q <= rem_q - RW'(1);
               if (rem_q == RW'(1)) begin
                  end_pend_q <= 1'b1;
                  state_q    <= S_SEARCH;
                  sr_q       <= '0;
               end
            end
         end
      end
   end

   assign hit_flag             = hit_q;
   assign payload_length       = len_q;
   assign payload_length_valid = len_vld_q;
   assign info_bit             = info_q;
   assign bit_valid            = bit_vld_q;
   assign octet                = octet_q;
   assign octet_valid          = oct_vld_q;
   assign decode_end           = dec_end_q;
   assign crc_ok               = crc_ok_q;
endmodule

// File: tb/tb_btle_rx_core_unit.sv
// tb/tb_btle_rx_core_unit.sv - scoreboard bench for btle_rx_core_unit
module tb_btle_rx_core_unit;
   localparam logic signed [15:0] AMP = 16'sd8000;
`ifdef BTLE_RX_DEWHITEN_EN
   localparam bit WHITE_EN = 1'b1;
`else
   localparam bit WHITE_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_n, iq_valid;
   logic [31:0]        aa;
   logic [5:0]         ch;
   logic [23:0]        crc_init;
   logic signed [15:0] i_s, q_s;
   logic               hit_flag, payload_length_valid, info_bit, bit_valid;
   logic               octet_valid, decode_end, crc_ok;
   logic [6:0]         payload_length;
   logic [7:0]         octet;

   btle_rx_core_unit dut (
      .clk(clk), .rst_n(rst_n), .unique_bit_sequence(aa), .channel_number(ch),
      .crc_state_init_bit(crc_init), .i(i_s), .q(q_s), .iq_valid(iq_valid),
      .hit_flag(hit_flag), .payload_length(payload_length),
      .payload_length_valid(payload_length_valid), .info_bit(info_bit),
      .bit_valid(bit_valid), .octet(octet), .octet_valid(octet_valid),
      .decode_end(decode_end), .crc_ok(crc_ok)
   );

   int n_pass = 0, n_fail = 0;
   bit         exp_bits[$];
   logic [7:0] exp_oct[$];
   logic [6:0] exp_len[$];
   bit         exp_crc[$];
   bit         air[$];
   int hit_cnt = 0, bit_cnt = 0, oct_cnt = 0, dec_cnt = 0;
   int bits_at_len = 0, last_span = 0, ph = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit wbit(input logic [5:0] c, input int n);
      bit r[7];
      bit w;
      r[0] = 1'b1;
      for (int k = 1; k < 7; k++) r[k] = c[6-k];
      for (int s = 0; s < n; s++) begin
         w = r[6];
         for (int k = 6; k > 0; k--) r[k] = r[k-1];
         r[0] = w;
         r[4] = r[4] ^ w;
      end
      return WHITE_EN && r[6];
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (payload_length_valid) begin
            bits_at_len = bit_cnt;
            check("len_q_nonempty", 32'(exp_len.size() != 0), 1);
            if (exp_len.size() != 0) check("payload_length", 32'(payload_length), 32'(exp_len.pop_front()));
         end
         if (bit_valid) begin
            bit_cnt++;
            check("bit_q_nonempty", 32'(exp_bits.size() != 0), 1);
            if (exp_bits.size() != 0) check("info_bit", 32'(info_bit), 32'(exp_bits.pop_front()));
         end
         if (octet_valid) begin
            oct_cnt++;
            check("oct_q_nonempty", 32'(exp_oct.size() != 0), 1);
            if (exp_oct.size() != 0) check("octet", 32'(octet), 32'(exp_oct.pop_front()));
         end
         if (hit_flag) hit_cnt++;
         if (decode_end) begin
            dec_cnt++;
            last_span = bit_cnt - bits_at_len;
            check("crc_q_nonempty", 32'(exp_crc.size() != 0), 1);
            if (exp_crc.size() != 0) check("crc_ok", 32'(crc_ok), 32'(exp_crc.pop_front()));
         end
      end
   end

   task automatic drive_sample(input logic signed [15:0] si, input logic signed [15:0] sq, input int gap);
      @(negedge clk);
      i_s = si;
      q_s = sq;
      iq_valid = 1'b1;
      if (gap > 0) begin
         @(negedge clk);
         iq_valid = 1'b0;
         repeat (gap - 1) @(negedge clk);
      end
   endtask

   task automatic send_bit(input bit b, input int gap);
      ph = b ? (ph + 1) % 4 : (ph + 3) % 4;
      case (ph)
         0:       drive_sample(AMP, 16'sd0, gap);
         1:       drive_sample(16'sd0, AMP, gap);
         2:       drive_sample(-AMP, 16'sd0, gap);
         default: drive_sample(16'sd0, -AMP, gap);
      endcase
   endtask

   task automatic send_packet(input int len, input bit embed, input int flip, input int stop_after);
      bit         info[$];
      logic [23:0] s;
      logic [7:0]  b;
      bit          fb;
      air.delete();
      b = 8'h42;
      for (int k = 0; k < 8; k++) info.push_back(b[k]);
      b = 8'(len);
      for (int k = 0; k < 8; k++) info.push_back(b[k]);
      for (int k = 0; k < 8 * len; k++) begin
         if (embed && k < 32) info.push_back(aa[k] ^ wbit(ch, 16 + k));
         else                 info.push_back(1'($urandom_range(0, 1)));
      end
      s = crc_init;
      foreach (info[n]) begin
         fb = s[23] ^ info[n];
         s  = {s[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h000000);
      end
      for (int k = 23; k >= 0; k--) info.push_back(s[k]);
      if (flip >= 0) info[16 + flip] = ~info[16 + flip];
      foreach (info[n]) exp_bits.push_back(info[n]);
      for (int o = 0; o < info.size() / 8; o++) begin
         for (int k = 0; k < 8; k++) b[k] = info[8 * o + k];
         exp_oct.push_back(b);
      end
      exp_len.push_back(7'(len));
      exp_crc.push_back(flip < 0);
      for (int k = 0; k < 8; k++) air.push_back(1'(k & 1));
      for (int k = 0; k < 32; k++) air.push_back(aa[k]);
      foreach (info[n]) air.push_back(info[n] ^ wbit(ch, n));
      for (int n = 0; n < air.size() && n < stop_after; n++) send_bit(air[n], $urandom_range(0, 2));
      @(negedge clk);
      iq_valid = 1'b0;
   endtask

   task automatic wait_dec(input int target, input string tag);
      for (int k = 0; k < 400 && dec_cnt < target; k++) @(negedge clk);
      check(tag, dec_cnt, target);
   endtask

   function automatic logic [31:0] all_outputs();
      return 32'({hit_flag, payload_length, payload_length_valid, info_bit, bit_valid,
                  octet, octet_valid, decode_end, crc_ok});
   endfunction

   initial begin
      int h0, o0, d0, b0;
      rst_n = 1'b0; iq_valid = 1'b0; i_s = '0; q_s = '0;
      aa = 32'h8E89BED6; ch = 6'd37; crc_init = 24'h555555;
      repeat (3) @(negedge clk);
      check("reset_outputs", all_outputs(), 0);
      rst_n = 1'b1;

      h0 = hit_cnt; o0 = oct_cnt; d0 = dec_cnt;
      send_packet(6, 1'b0, -1, 100000);
      wait_dec(d0 + 1, "t1_decode_end");
      check("t1_hits", hit_cnt - h0, 1);
      check("t1_octets", oct_cnt - o0, 11);
      repeat (5) @(negedge clk);
      check("t1_crc_held", 32'(crc_ok), 1);

      h0 = hit_cnt; o0 = oct_cnt; d0 = dec_cnt;
      send_packet(6, 1'b0, 13, 100000);
      wait_dec(d0 + 1, "t2_decode_end");
      check("t2_octets", oct_cnt - o0, 11);
      repeat (5) @(negedge clk);
      check("t2_crc_held", 32'(crc_ok), 0);

      h0 = hit_cnt; b0 = bit_cnt; d0 = dec_cnt;
      for (int n = 0; n < 200; n++) drive_sample(16'($urandom), 16'($urandom), $urandom_range(0, 2));
      @(negedge clk);
      iq_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("t3_no_hit", hit_cnt - h0, 0);
      check("t3_no_bits", bit_cnt - b0, 0);
      check("t3_no_end", dec_cnt - d0, 0);

      h0 = hit_cnt; o0 = oct_cnt; d0 = dec_cnt;
      send_packet(8, 1'b1, -1, 100000);
      wait_dec(d0 + 1, "t4_decode_end");
      check("t4_single_hit", hit_cnt - h0, 1);
      check("t4_octets", oct_cnt - o0, 13);

      d0 = dec_cnt;
      send_packet(6, 1'b0, -1, 76);
      rst_n = 1'b0;
      @(negedge clk);
      check("t5_reset_outputs", all_outputs(), 0);
      repeat (4) @(negedge clk);
      check("t5_reset_outputs_late", all_outputs(), 0);
      check("t5_no_end", dec_cnt - d0, 0);
      exp_bits.delete(); exp_oct.delete(); exp_len.delete(); exp_crc.delete();
      rst_n = 1'b1;
      h0 = hit_cnt; o0 = oct_cnt; d0 = dec_cnt;
      send_packet(6, 1'b0, -1, 100000);
      wait_dec(d0 + 1, "t5_decode_end");
      check("t5_hits", hit_cnt - h0, 1);
      check("t5_octets", oct_cnt - o0, 11);
      check("t5_crc_held", 32'(crc_ok), 1);

      o0 = oct_cnt; d0 = dec_cnt;
      send_packet(0, 1'b0, -1, 100000);
      wait_dec(d0 + 1, "t6_decode_end");
      check("t6_octets", oct_cnt - o0, 5);
      check("t6_crc_span", last_span, 24);
      check("t6_crc_held", 32'(crc_ok), 1);

      check("bits_drained", exp_bits.size(), 0);
      check("octets_drained", exp_oct.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, passed %0d", n_pass);
      $fatal(1, "watchdog");
   end
endmodule
